exc_sequencer: RTL

- Trap/return sequencer directly upstream of the CP0 block.
- Consumes decoded syscall/break/teq/eret from the execute stage, gates them with the CP0 status word, and drives CP0's exception/eret/cause/pc inputs for exactly one cycle.
- Then redirects the fetch PC to the handler vector, or to the CP0-returned EPC, while stalling the pipeline.
- Tracks nesting depth so CP0's 5-bit status shift stack is never over- or under-run.

---
 rtl/exc_sequencer_if.sv | 36 +++
 rtl/exc_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/exc_sequencer_if.sv
`default_nettype none
//=============================================================================
// exc_sequencer_if - execute-stage/CP0 handshake bundle for the trap sequencer. Rev 1.0
//=============================================================================
interface exc_sequencer_if;
  logic        instr_valid;
  logic        is_syscall;
  logic        is_break;
  logic        is_teq;
  logic        teq_eq;
  logic        is_eret;
  logic [31:0] inst_pc;
  logic [31:0] status;
  logic [31:0] epc_in;
  logic        stall;
  logic        exception;
  logic        eret;
  logic [4:0]  cause;
  logic [31:0] exc_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  depth;

  modport master (
    output instr_valid, is_syscall, is_break, is_teq, teq_eq, is_eret,
    output inst_pc, status, epc_in,
    input  stall, exception, eret, cause, exc_pc, redirect, redirect_pc, depth
  );

  modport slave (
    input  instr_valid, is_syscall, is_break, is_teq, teq_eq, is_eret,
    input  inst_pc, status, epc_in,
    output stall, exception, eret, cause, exc_pc, redirect, redirect_pc, depth
  );
endinterface
`default_nettype wire

// File: rtl/exc_sequencer.sv
`default_nettype none
//=============================================================================
// exc_sequencer - gates trap/eret requests, pulses CP0, then redirects fetch. Rev 1.0
//=============================================================================
module exc_sequencer #(
  parameter logic [31:0] VECTOR    = 32'h00400004,
  parameter int          MAX_DEPTH = 6
) (
  input  wire logic       clk,
  input  wire logic       rst,
  exc_sequencer_if.slave  seq_if
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SIGNAL   = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;

  localparam logic [2:0] C_MAX_DEPTH = 3'(MAX_DEPTH);
  localparam logic [4:0] C_CAUSE_SYS = 5'b01000;
  localparam logic [4:0] C_CAUSE_BRK = 5'b01001;
  localparam logic [4:0] C_CAUSE_TEQ = 5'b01101;

  logic [1:0]  state_q, state_d;
  logic        exception_q, exception_d;
  logic        eret_q, eret_d;
  logic        redirect_q, redirect_d;
  logic [4:0]  cause_q, cause_d;
  logic [31:0] exc_pc_q, exc_pc_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] epc_q, epc_d;
  logic        kind_trap_q, kind_trap_d;
  logic [2:0]  depth_q, depth_d;

  logic        w_trap_req;
  logic        w_eret_req;
  logic        w_enable;
  logic [4:0]  w_cause;
  logic        w_accept;
  logic        w_unused_status;

  assign w_unused_status = ^seq_if.status[31:4];

  // Only the highest-priority flag is considered; a TEQ with unequal operands masks lower flags.
  always_comb begin
    w_trap_req = 1'b0;
    w_eret_req = 1'b0;
    w_enable   = 1'b0;
    w_cause    = 5'd0;
    if (seq_if.is_syscall) begin
      w_trap_req = 1'b1;
      w_cause    = C_CAUSE_SYS;
      w_enable   = seq_if.status[0] & seq_if.status[1];
    end else if (seq_if.is_break) begin
      w_trap_req = 1'b1;
      w_cause    = C_CAUSE_BRK;
      w_enable   = seq_if.status[0] & seq_if.status[2];
    end else if (seq_if.is_teq) begin
      w_trap_req = seq_if.teq_eq;
      w_cause    = C_CAUSE_TEQ;
      w_enable   = seq_if.status[0] & seq_if.status[3];
    end else if (seq_if.is_eret) begin
      w_eret_req = 1'b1;
      w_enable   = (depth_q != 3'd0);
    end
  end

  assign w_accept = seq_if.instr_valid & (state_q == S_IDLE) & w_enable &
                    ((w_trap_req & (depth_q < C_MAX_DEPTH)) | w_eret_req);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      exception_q   <= 1'b0;
      eret_q        <= 1'b0;
      redirect_q    <= 1'b0;
      cause_q       <= 5'd0;
      exc_pc_q      <= 32'd0;
      redirect_pc_q <= 32'd0;
      epc_q         <= 32'd0;
      kind_trap_q   <= 1'b0;
      depth_q       <= 3'd0;
    end else begin
      state_q       <= state_d;
      exception_q   <= exception_d;
      eret_q        <= eret_d;
      redirect_q    <= redirect_d;
      cause_q       <= cause_d;
      exc_pc_q      <= exc_pc_d;
      redirect_pc_q <= redirect_pc_d;
      epc_q         <= epc_d;
      kind_trap_q   <= kind_trap_d;
      depth_q       <= depth_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (w_accept) state_d = S_SIGNAL;
      S_SIGNAL:   state_d = S_REDIRECT;
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    exception_d   = 1'b0;
    eret_d        = 1'b0;
    redirect_d    = 1'b0;
    cause_d       = cause_q;
    exc_pc_d      = exc_pc_q;
    redirect_pc_d = redirect_pc_q;
    epc_d         = epc_q;
    kind_trap_d   = kind_trap_q;
    depth_d       = depth_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          exception_d = w_trap_req;
          eret_d      = ~w_trap_req;
          cause_d     = w_trap_req ? w_cause : 5'd0;
          exc_pc_d    = seq_if.inst_pc;
          kind_trap_d = w_trap_req;
        end
      end
      S_SIGNAL: begin
        redirect_d = 1'b1;
        // epc_in is only valid while eret is high, so it feeds the redirect target directly.
        if (kind_trap_q) begin
          redirect_pc_d = VECTOR;
        end else begin
          redirect_pc_d = seq_if.epc_in;
          epc_d         = seq_if.epc_in;
        end
      end
      S_REDIRECT: begin
        if (kind_trap_q && (depth_q < C_MAX_DEPTH)) begin
          depth_d = depth_q + 3'd1;
        end else if (!kind_trap_q && (depth_q != 3'd0)) begin
          depth_d = depth_q - 3'd1;
        end
      end
      default: ;
    endcase
  end

  assign seq_if.stall       = w_accept | (state_q != S_IDLE);
  assign seq_if.exception   = exception_q;
  assign seq_if.eret        = eret_q;
  assign seq_if.redirect    = redirect_q;
  assign seq_if.cause       = cause_q;
  assign seq_if.exc_pc      = exc_pc_q;
  assign seq_if.redirect_pc = redirect_pc_q;
  assign seq_if.depth       = depth_q;

endmodule
`default_nettype wire
